// File: rtl/mul_req_scheduler.sv
// Round-robin front end that shares one iterative multiplier core between NREQ requesters
// and returns each tagged product, or a timeout error, on a single valid/ready channel.
module mul_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                areset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_id,
    output logic [2*W-1:0]      rsp_product,
    output logic                rsp_err,
    output logic                core_load,
    output logic [W-1:0]        core_a,
    output logic [W-1:0]        core_b,
    input  logic                core_done,
    input  logic [2*W-1:0]      core_product
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   id_reg;
    logic [W-1:0]    a_reg, b_reg;
    logic [TW-1:0]   timer;
    logic [2*W-1:0]  product_reg;
    logic            err_reg;

    logic            grant_found, hi_found;
    logic [IW-1:0]   grant_idx, hi_idx, lo_idx;
    logic [W-1:0]    grant_a, grant_b;
    logic            timer_expired;

    // Priority starts just above rr_ptr: the lowest valid index above it wins,
    // otherwise wrap to the lowest valid index overall.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        hi_found    = 1'b0;
        hi_idx      = '0;
        grant_found = 1'b0;
        lo_idx      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IW'(i) > rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
                grant_found = 1'b1;
                lo_idx      = IW'(i);
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    assign grant_a       = req_a[int'(grant_idx) * W +: W];
    assign grant_b       = req_b[int'(grant_idx) * W +: W];
    assign timer_expired = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_found)
                      state_next = (grant_a == '0 || grant_b == '0) ? RESP : LOAD;
            LOAD: state_next = WAIT;
            WAIT: if (core_done || timer_expired)
                      state_next = RESP;
            RESP: if (rsp_ready)
                      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (areset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            rr_ptr      <= IW'(NREQ - 1);
            id_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            timer       <= '0;
            product_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_found) begin
                    a_reg       <= grant_a;
                    b_reg       <= grant_b;
                    id_reg      <= grant_idx;
                    product_reg <= '0;
                    err_reg     <= 1'b0;
                end
                LOAD: timer <= '0;
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A done arriving on the expiry cycle still wins over the abort.
                    if (core_done) begin
                        product_reg <= core_product;
                        err_reg     <= 1'b0;
                    end else if (timer_expired) begin
                        product_reg <= '0;
                        err_reg     <= 1'b1;
                    end
                end
                RESP: if (rsp_ready)
                    rr_ptr <= id_reg;
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (state == RESP);
    assign core_load   = (state == LOAD);
    assign core_a      = a_reg;
    assign core_b      = b_reg;
    assign rsp_id      = 3'(id_reg);
    assign rsp_product = product_reg;
    assign rsp_err     = err_reg;

endmodule

// File: tb/tb_mul_req_scheduler.sv
// Directed bench for mul_req_scheduler with a behavioural multiplier core of fixed latency.
module tb_mul_req_scheduler;

    localparam int NREQ     = 4;
    localparam int W        = 8;
    localparam int TIMEOUT  = 15;
    localparam int CORE_LAT = 9;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [2:0]        rsp_id;
    logic [2*W-1:0]    rsp_product;
    logic              rsp_err;
    logic              core_load;
    logic [W-1:0]      core_a, core_b;
    logic              core_done;
    logic [2*W-1:0]    core_product;

    int total = 0;
    int bad   = 0;

    mul_req_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .core_load(core_load), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_product(core_product)
    );

    always #5 clk = ~clk;

    // Core model: done in the CORE_LAT-th cycle after the load pulse, unless disabled.
    logic         core_busy = 1'b0;
    int           core_cnt = 0;
    logic [W-1:0] ca = '0, cb = '0;
    bit           core_en = 1'b1;
    bit           force_done = 1'b0;

    always @(posedge clk) begin
        if (core_load) begin
            core_busy <= 1'b1;
            core_cnt  <= 0;
            ca        <= core_a;
            cb        <= core_b;
        end else if (core_busy) begin
            if (core_done) core_busy <= 1'b0;
            else           core_cnt  <= core_cnt + 1;
        end
    end

    assign core_done    = (core_busy && core_en && core_cnt == CORE_LAT - 1) || force_done;
    assign core_product = {{W{1'b0}}, ca} * {{W{1'b0}}, cb};

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (req_ready == '0 && n < 50) begin @(negedge clk); #1; n++; end
    endtask

    task automatic wait_rsp(output int n, output int loads);
        n = 0; loads = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk); #1; n++;
            if (core_load) loads++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
        total++; if (core_load !== 1'b0) begin bad++; $display("FAIL reset_core_load got=%0h exp=0", core_load); end
        total++; if (core_a !== 8'd0 || core_b !== 8'd0) begin bad++; $display("FAIL reset_core_ab got=%0h/%0h exp=0/0", core_a, core_b); end
        total++; if (rsp_id !== 3'd0) begin bad++; $display("FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
        total++; if (rsp_product !== 16'd0) begin bad++; $display("FAIL reset_rsp_product got=%0h exp=0", rsp_product); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%0h exp=0", rsp_err); end
        total++; if (dut.rr_ptr !== 2'd3) begin bad++; $display("FAIL reset_rr_ptr got=%0h exp=3", dut.rr_ptr); end
    endtask

    task automatic test_single();
        int n, loads;
        set_req(0, 8'd13, 8'd11);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%0h exp=1", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        total++; if (core_load !== 1'b1) begin bad++; $display("FAIL single_load_c1 got=%0h exp=1", core_load); end
        total++; if (core_a !== 8'd13 || core_b !== 8'd11) begin bad++; $display("FAIL single_core_ab got=%0d/%0d exp=13/11", core_a, core_b); end
        wait_rsp(n, loads);
        total++; if (n !== 10) begin bad++; $display("FAIL single_latency got=%0d exp=10", n); end
        total++; if (loads !== 0) begin bad++; $display("FAIL single_load_width extra=%0d exp=0", loads); end
        total++; if (rsp_id !== 3'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
        total++; if (rsp_product !== 16'd143) begin bad++; $display("FAIL single_product got=%0d exp=143", rsp_product); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL single_err got=%0h exp=0", rsp_err); end
        handshake();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_drop got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int n, loads;
        int exp_id [5];
        int exp_p  [5];
        logic [NREQ-1:0] exp_rdy;
        exp_id = '{0, 1, 2, 3, 0};
        exp_p  = '{6, 9, 12, 15, 6};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 2), 8'd3);
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            exp_rdy = 4'b0001 << exp_id[k];
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d got=%0h exp=%0h", k, req_ready, exp_rdy); end
            @(negedge clk); #1;
            wait_rsp(n, loads);
            total++; if (rsp_id !== 3'(exp_id[k])) begin bad++; $display("FAIL rr_id%0d got=%0d exp=%0d", k, rsp_id, exp_id[k]); end
            total++; if (rsp_product !== 16'(exp_p[k])) begin bad++; $display("FAIL rr_product%0d got=%0d exp=%0d", k, rsp_product, exp_p[k]); end
            handshake();
        end
        req_valid = '0;
    endtask

    task automatic test_zero_operand();
        int loads;
        set_req(2, 8'd0, 8'd200);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL zero_grant got=%0h exp=4", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        loads = core_load ? 1 : 0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL zero_rsp_c1 got=%0h exp=1", rsp_valid); end
        total++; if (loads !== 0) begin bad++; $display("FAIL zero_no_load got=%0d exp=0", loads); end
        total++; if (rsp_product !== 16'd0) begin bad++; $display("FAIL zero_product got=%0h exp=0", rsp_product); end
        total++; if (rsp_id !== 3'd2) begin bad++; $display("FAIL zero_id got=%0d exp=2", rsp_id); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL zero_err got=%0h exp=0", rsp_err); end
        handshake();
    endtask

    task automatic test_backpressure();
        int n, loads;
        set_req(3, 8'd255, 8'd255);
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant got=%0h exp=8", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        wait_rsp(n, loads);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp got=%0h exp=1", rsp_valid); end
        set_req(0, 8'd1, 8'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%0h exp=1", c, rsp_valid); end
            total++; if (rsp_product !== 16'hFE01) begin bad++; $display("FAIL bp_product_c%0d got=%0h exp=fe01", c, rsp_product); end
            total++; if (rsp_id !== 3'd3) begin bad++; $display("FAIL bp_id_c%0d got=%0d exp=3", c, rsp_id); end
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_no_accept_c%0d got=%0h exp=0", c, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = '0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%0h exp=0", rsp_valid); end
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_single_hs got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_timeout();
        int n, loads;
        core_en = 1'b0;
        set_req(1, 8'd5, 8'd6);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL to_grant got=%0h exp=2", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        wait_rsp(n, loads);
        total++; if (n !== 16) begin bad++; $display("FAIL to_latency got=%0d exp=16", n); end
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0h exp=1", rsp_err); end
        total++; if (rsp_product !== 16'd0) begin bad++; $display("FAIL to_product got=%0h exp=0", rsp_product); end
        @(negedge clk); force_done = 1'b1;
        @(negedge clk); force_done = 1'b0; #1;
        total++; if (rsp_err !== 1'b1 || rsp_product !== 16'd0) begin bad++; $display("FAIL to_late_done_resp got=%0h/%0h exp=1/0", rsp_err, rsp_product); end
        handshake();
        @(negedge clk); force_done = 1'b1;
        @(negedge clk); force_done = 1'b0; #1;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL to_late_done_idle got=%0h/%0h exp=0/0", rsp_valid, req_ready); end
        core_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int n, loads;
        set_req(1, 8'd3, 8'd4);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rw_grant got=%0h exp=2", req_ready); end
        @(negedge clk); req_valid = '0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rw_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if (core_load !== 1'b0 || core_a !== 8'd0) begin bad++; $display("FAIL rw_core got=%0h/%0h exp=0/0", core_load, core_a); end
        total++; if (dut.rr_ptr !== 2'd3) begin bad++; $display("FAIL rw_rr_ptr got=%0h exp=3", dut.rr_ptr); end
        set_req(0, 8'd7, 8'd8);
        set_req(1, 8'd3, 8'd4);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rw_first_grant got=%0h exp=1", req_ready); end
        @(negedge clk); req_valid[0] = 1'b0; #1;
        wait_rsp(n, loads);
        total++; if (rsp_id !== 3'd0 || rsp_product !== 16'd56) begin bad++; $display("FAIL rw_first_rsp got=%0d/%0d exp=0/56", rsp_id, rsp_product); end
        handshake();
        wait_grant(n);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rw_second_grant got=%0h exp=2", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        wait_rsp(n, loads);
        total++; if (rsp_id !== 3'd1 || rsp_product !== 16'd12 || rsp_err !== 1'b0) begin bad++; $display("FAIL rw_second_rsp got=%0d/%0d/%0h exp=1/12/0", rsp_id, rsp_product, rsp_err); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_operand();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
